instr_decoder: RTL and testbench
================================

// Module: instr_decoder
// PURPOSE
//  RV32I decode stage. Accepts an instruction word plus PC from fetch, produces the 12-bit ALU
//  operation code ({funct bits, opcode}), immediate, register indices and control flags consumed
//  by the alu. Registered output with 2-entry skid buffer; valid/ready on both sides, plus flush.
// PARAMETERS
//  XLEN  32  data/PC width; immediates sign-extended to XLEN
// PORTS
//  clk        in   1     clock, all state on posedge
//  rst        in   1     synchronous active-high reset
//  flush      in   1     discard all held/incoming instructions (taken branch/jump)
//  in_valid   in   1     fetch offers instr/in_pc
//  in_ready   out  1     decoder can accept (registered: !skid_valid)
//  instr      in   32    instruction word
//  in_pc      in   XLEN  PC of instr
//  out_valid  out  1     decoded fields valid
//  out_ready  in   1     execute consumes decoded fields
//  operation  out  12    ALU op code, encoding below
//  imm        out  XLEN  immediate
//  rs1,rs2,rd out  5     register indices
//  use_imm    out  1     opr2 = imm (else rs2 data)
//  reg_write  out  1     writes rd
//  out_pc     out  XLEN  PC of decoded instr
//  illegal    out  1     unsupported encoding (see CONFIGURATION)
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, all data outputs 0. rst overrides flush and handshakes.
//  operation[6:0]=opcode. [9:7]=funct3 for OP, OP-IMM, LOAD, STORE, BRANCH; 000 for LUI, AUIPC, JAL, JALR.
//  [11]=instr[30] for OP only. [10]=instr[30] for OP-IMM with funct3=101 only. Otherwise 0.
//  imm: I=sext(instr[31:20]); OP-IMM shifts: zero-extended instr[24:20]; S; B; J=sext offsets (bit0=0);
//   U={instr[31:12],12'b0}; OP: imm=0.
//  use_imm=1 for OP-IMM, LOAD, STORE, LUI, AUIPC, JAL, JALR; 0 for OP, BRANCH.
//  reg_write=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only if rd!=0.
//  rs1 forced 0 for LUI, AUIPC, JAL. rs2 forced 0 unless OP/STORE/BRANCH. rd forced 0 for STORE/BRANCH.
//  Pipeline: main reg (M) + skid reg (S). States EMPTY(M,S empty), ONE(M full), TWO(M,S full).
//   EMPTY: accept -> ONE.
//   ONE: accept&consume -> ONE (M reloaded); accept only -> TWO (new beat into S);
//    consume only -> EMPTY.
//   TWO: in_ready=0; consume -> ONE, S moves to M same edge.
//  Latency 1: beat accepted at edge N drives outputs after edge N. Full throughput with out_ready=1.
//  Outputs stable while out_valid&!out_ready. Order preserved, no drop/duplicate.
//  flush: next edge -> EMPTY, out_valid=0, in_ready=1. Beat offered in the flush cycle is dropped.
// CONFIGURATION
//  DECODER_ILLEGAL_CHECK_EN defined: illegal=1 for unknown opcode, instr[1:0]!=11,
//   BRANCH funct3 010/011, LOAD funct3 011/110/111, STORE funct3>=011, JALR funct3!=0,
//   OP funct7 not 0000000/0100000 (0100000 only with funct3 000/101), bad OP-IMM shift funct7.
//   Illegal beats still flow through the handshake with operation=0, reg_write=0, imm=0.
//  Not defined: illegal tied 0; fields decoded from raw bits with no legality check.
// TESTING
//  1 rst 2 cycles -> out_valid=0, in_ready=1, operation=0, imm=0.
//  2 instr=0x40B50533 (sub) -> next cycle operation=12'b100000110011, rs1=10, rs2=11, rd=10,
//    use_imm=0, reg_write=1.
//  3 instr=0x40335293 (srai x5,x6,3) -> operation=12'b011010010011, imm=3, use_imm=1, rd=5.
//  4 instr=0xFE208CE3 (beq x1,x2,-8) -> operation=12'b000001100011, imm=0xFFFFFFF8,
//    reg_write=0, use_imm=0.
//  5 out_ready=0, feed A,B,C back-to-back -> A held, B in skid, in_ready=0, C not taken;
//    out_ready=1 -> A,B,C out in order, no gaps after C accepted.
//  6 flush in state TWO -> next cycle out_valid=0, in_ready=1; with macro, instr=0x00000000
//    -> illegal=1, operation=0, reg_write=0; without macro -> illegal=0.

Source files
------------

// File: rtl/instr_decoder.sv
// instr_decoder: RV32I decode stage with a registered output and skid buffer; `define DECODER_ILLEGAL_CHECK_EN to enable legality checks
module instr_decoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [11:0]     operation,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            use_imm,
  output logic            reg_write,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [11:0]     op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            use_imm;
    logic            reg_write;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } beat_t;
  state_t state_q, state_d;
  beat_t m_q, m_d, s_q, s_d, dec;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [31:0] imm32;
  logic is_op, is_opi, is_ld, is_st, is_br, is_lui, is_aui, is_jal, is_jalr, shift, bad, acc, cons;
  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign is_op   = opc == 7'b0110011;
  assign is_opi  = opc == 7'b0010011;
  assign is_ld   = opc == 7'b0000011;
  assign is_st   = opc == 7'b0100011;
  assign is_br   = opc == 7'b1100011;
  assign is_lui  = opc == 7'b0110111;
  assign is_aui  = opc == 7'b0010111;
  assign is_jal  = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;
  assign shift   = is_opi && f3[1:0] == 2'b01;
`ifdef DECODER_ILLEGAL_CHECK_EN
  logic [6:0] f7;
  assign f7 = instr[31:25];
  // flag any encoding outside the supported RV32I subset
  always_comb begin
    bad = !(is_op | is_opi | is_ld | is_st | is_br | is_lui | is_aui | is_jal | is_jalr)
        | (instr[1:0] != 2'b11)
        | (is_br && (f3 == 3'b010 || f3 == 3'b011))
        | (is_ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
        | (is_st && f3 >= 3'b011)
        | (is_jalr && f3 != 3'b000)
        | (is_op && !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
        | (shift && !(f7 == 7'b0 || (f3 == 3'b101 && f7 == 7'b0100000)));
  end
`else
  assign bad = 1'b0;
`endif
  assign imm32 = shift                     ? {27'd0, instr[24:20]} :
                 (is_opi | is_ld | is_jalr) ? {{20{instr[31]}}, instr[31:20]} :
                 is_st                     ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                 is_br                     ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                 is_jal                    ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                 (is_lui | is_aui)         ? {instr[31:12], 12'd0} : 32'd0;
  // combinational decode of the offered instruction into a pipeline beat
  always_comb begin
    dec.op        = bad ? 12'd0 : {is_op & instr[30], is_opi & (f3 == 3'b101) & instr[30],
                                   (is_op | is_opi | is_ld | is_st | is_br) ? f3 : 3'b000, opc};
    dec.imm       = bad ? '0 : XLEN'($signed(imm32));
    dec.rs1       = (is_lui | is_aui | is_jal) ? 5'd0 : instr[19:15];
    dec.rs2       = (is_op | is_st | is_br) ? instr[24:20] : 5'd0;
    dec.rd        = (is_st | is_br) ? 5'd0 : instr[11:7];
    dec.use_imm   = is_opi | is_ld | is_st | is_lui | is_aui | is_jal | is_jalr;
    dec.reg_write = !bad && (is_op | is_opi | is_ld | is_lui | is_aui | is_jal | is_jalr) && instr[11:7] != 5'd0;
    dec.pc        = in_pc;
    dec.illegal   = bad;
  end
  assign in_ready  = state_q != TWO;
  assign out_valid = state_q != EMPTY;
  assign acc       = in_valid && in_ready && !flush;
  assign cons      = out_valid && out_ready;
  // main/skid occupancy FSM; skid drains into main on the edge main is consumed
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) state_d = EMPTY;
    else if (state_q == EMPTY) begin
      if (acc) begin
        state_d = ONE;
        m_d     = dec;
      end
    end else if (state_q == ONE) begin
      if (acc && cons) m_d = dec;
      else if (acc) begin
        state_d = TWO;
        s_d     = dec;
      end else if (cons) state_d = EMPTY;
    end else if (cons) begin
      state_d = ONE;
      m_d     = s_q;
    end
  end
  // state and beat registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end
  assign operation = m_q.op;
  assign imm       = m_q.imm;
  assign rs1       = m_q.rs1;
  assign rs2       = m_q.rs2;
  assign rd        = m_q.rd;
  assign use_imm   = m_q.use_imm;
  assign reg_write = m_q.reg_write;
  assign out_pc    = m_q.pc;
  assign illegal   = m_q.illegal;
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: table-driven decode vectors plus skid-buffer and flush sequences
module tb_instr_decoder;
  logic clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready, use_imm, reg_write, illegal;
  logic [31:0] instr, in_pc, imm, out_pc;
  logic [11:0] operation;
  logic [4:0] rs1, rs2, rd;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [31:0] instr;
    logic [11:0] op;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        ui, rw;
  } vec_t;
  vec_t v[10];
  always #5 clk = ~clk;
  instr_decoder dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .operation(operation), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .use_imm(use_imm), .reg_write(reg_write), .out_pc(out_pc), .illegal(illegal)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic vld, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = vld;
    instr    = ins;
    in_pc    = pc;
  endtask
  initial begin
    v[0] = '{32'h40B50533, 12'h833, 32'h0,        5'd10, 5'd11, 5'd10, 1'b0, 1'b1};
    v[1] = '{32'h40335293, 12'h693, 32'h3,        5'd6,  5'd0,  5'd5,  1'b1, 1'b1};
    v[2] = '{32'hFE208CE3, 12'h063, 32'hFFFFFFF8, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0};
    v[3] = '{32'hFFF00093, 12'h013, 32'hFFFFFFFF, 5'd0,  5'd0,  5'd1,  1'b1, 1'b1};
    v[4] = '{32'h123452B7, 12'h037, 32'h12345000, 5'd0,  5'd0,  5'd5,  1'b1, 1'b1};
    v[5] = '{32'h0020A423, 12'h123, 32'h8,        5'd1,  5'd2,  5'd0,  1'b1, 1'b0};
    v[6] = '{32'h010000EF, 12'h06F, 32'h10,       5'd0,  5'd0,  5'd1,  1'b1, 1'b1};
    v[7] = '{32'h00208033, 12'h033, 32'h0,        5'd1,  5'd2,  5'd0,  1'b0, 1'b0};
    v[8] = '{32'hFFC12183, 12'h103, 32'hFFFFFFFC, 5'd2,  5'd0,  5'd3,  1'b1, 1'b1};
    v[9] = '{32'h01F21213, 12'h093, 32'h1F,       5'd4,  5'd0,  5'd4,  1'b1, 1'b1};
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset operation", 64'(operation), 64'd0);
    chk("reset imm", 64'(imm), 64'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, v[i].instr, 32'h1000 + 32'(i) * 4);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0);
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d fields", i), {operation, imm, rs1, rs2, rd, use_imm, reg_write, illegal},
          {v[i].op, v[i].imm, v[i].rs1, v[i].rs2, v[i].rd, v[i].ui, v[i].rw, 1'b0});
      chk($sformatf("vec%0d pc", i), 64'(out_pc), 64'(32'h1000 + 32'(i) * 4));
    end
    @(negedge clk);
    chk("drain out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, v[0].instr, 32'h100);
    @(negedge clk);
    chk("skid A valid", 64'(out_valid), 64'd1);
    chk("skid A pc", 64'(out_pc), 64'h100);
    chk("skid ONE in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, v[1].instr, 32'h104);
    @(negedge clk);
    chk("skid A held pc", 64'(out_pc), 64'h100);
    chk("skid A held op", 64'(operation), 64'h833);
    chk("skid TWO in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, v[2].instr, 32'h108);
    @(negedge clk);
    chk("skid A still pc", 64'(out_pc), 64'h100);
    chk("skid C blocked", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("skid B pc", 64'(out_pc), 64'h104);
    chk("skid B op", 64'(operation), 64'h693);
    chk("skid B in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    chk("skid C valid", 64'(out_valid), 64'd1);
    chk("skid C pc", 64'(out_pc), 64'h108);
    chk("skid C imm", 64'(imm), 64'hFFFFFFF8);
    @(negedge clk);
    chk("skid empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, v[3].instr, 32'h200);
    @(negedge clk);
    drive(1'b1, v[4].instr, 32'h204);
    @(negedge clk);
    chk("flush pre TWO", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, v[5].instr, 32'h208);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("flush dropped", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h300);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    chk("zero instr valid", 64'(out_valid), 64'd1);
    chk("zero instr pc", 64'(out_pc), 64'h300);
`ifdef DECODER_ILLEGAL_CHECK_EN
    chk("zero instr illegal", 64'(illegal), 64'd1);
`else
    chk("zero instr illegal", 64'(illegal), 64'd0);
`endif
    chk("zero instr operation", 64'(operation), 64'd0);
    chk("zero instr reg_write", 64'(reg_write), 64'd0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
